// File: rtl/controller_dpram_pkg.sv
// Shared types and helpers for the controller dual-port scratch/mailbox RAM.
// Used by the RAM array and its controller.
package controller_dpram_pkg;

   typedef enum logic [0:0] {
      READY = 1'b0,
      CLEAR = 1'b1
   } state_e;

   localparam int COUNT_WIDTH = 16;

   function automatic bit latency_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/controller_dpram_array.sv
// True dual-port byte-enabled RAM with registered, enabled reads.
// A read and a write to the same word in one cycle return the old word.
module controller_dpram_array
   import controller_dpram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    a_wen,
   input  logic                    a_ren,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH/8-1:0] a_be,
   input  logic [DATA_WIDTH-1:0]   a_wdata,
   output logic [DATA_WIDTH-1:0]   a_q,
   input  logic                    b_wen,
   input  logic                    b_ren,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   input  logic [DATA_WIDTH/8-1:0] b_be,
   input  logic [DATA_WIDTH-1:0]   b_wdata,
   output logic [DATA_WIDTH-1:0]   b_q
);

   localparam int BE_WIDTH = be_width(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];

   // Byte-lane writes from both ports; callers keep same-word lane sets disjoint.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (a_wen && a_be[i]) begin
            mem_r[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
         end
         if (b_wen && b_be[i]) begin
            mem_r[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
         end
      end
   end

   // Read registers only load on a read, so they hold the last returned word.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_q <= {DATA_WIDTH{1'b0}};
         b_q <= {DATA_WIDTH{1'b0}};
      end else begin
         if (a_ren) begin
            a_q <= mem_r[a_addr];
         end
         if (b_ren) begin
            b_q <= mem_r[b_addr];
         end
      end
   end

endmodule

// File: rtl/controller_dpram_ctl.sv
// Dual Avalon-MM port scratch RAM controller: clear engine, s1-priority
// same-word write merging, collision counter and read latency pipelines.
module controller_dpram_ctl
   import controller_dpram_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 10,
   parameter int                    READ_LATENCY   = 1,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = {DATA_WIDTH{1'b0}}
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear_req,
   output logic                    busy,
   output logic [15:0]             collision_count,
   input  logic [ADDR_WIDTH-1:0]   s1_address,
   input  logic                    s1_chipselect,
   input  logic                    s1_read,
   input  logic                    s1_write,
   input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
   input  logic [DATA_WIDTH-1:0]   s1_writedata,
   output logic [DATA_WIDTH-1:0]   s1_readdata,
   output logic                    s1_readdatavalid,
   output logic                    s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]   s2_address,
   input  logic                    s2_chipselect,
   input  logic                    s2_read,
   input  logic                    s2_write,
   input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
   input  logic [DATA_WIDTH-1:0]   s2_writedata,
   output logic [DATA_WIDTH-1:0]   s2_readdata,
   output logic                    s2_readdatavalid,
   output logic                    s2_waitrequest
);

   localparam int                    BE_WIDTH    = be_width(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam state_e                RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

   if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
      $error("controller_dpram_ctl: READ_LATENCY must be 1 or 2");
   end

   state_e                  state_r, state_next_s;
   logic [ADDR_WIDTH-1:0]   clr_addr_r, clr_addr_next_s;
   logic                    busy_r;
   logic [COUNT_WIDTH-1:0]  coll_r;
   logic                    s1_vld1_r, s2_vld1_r;

   logic s1_acc_s, s1_wen_s, s1_ren_s, s2_acc_s, s2_wen_s, s2_ren_s;
   logic same_word_s, overlap_s;
   logic [BE_WIDTH-1:0]   s2_be_eff_s, a_be_s;
   logic                  a_wen_s;
   logic [ADDR_WIDTH-1:0] a_addr_s;
   logic [DATA_WIDTH-1:0] a_wdata_s, a_q_s, b_q_s;

   assign s1_acc_s    = s1_chipselect & (s1_read | s1_write) & ~busy_r;
   assign s2_acc_s    = s2_chipselect & (s2_read | s2_write) & ~busy_r;
   assign s1_wen_s    = s1_acc_s & s1_write;
   assign s2_wen_s    = s2_acc_s & s2_write;
   assign s1_ren_s    = s1_acc_s & s1_read & ~s1_write;
   assign s2_ren_s    = s2_acc_s & s2_read & ~s2_write;
   assign same_word_s = s1_wen_s & s2_wen_s & (s1_address == s2_address);
   assign overlap_s   = same_word_s & (|(s1_byteenable & s2_byteenable));
   assign s2_be_eff_s = same_word_s ? (s2_byteenable & ~s1_byteenable) : s2_byteenable;

   // Clear FSM next state: walks every address once, then returns to READY.
   always_comb begin
      state_next_s    = state_r;
      clr_addr_next_s = clr_addr_r;
      case (state_r)
         READY: begin
            if (clear_req) begin
               state_next_s    = CLEAR;
               clr_addr_next_s = {ADDR_WIDTH{1'b0}};
            end else begin
               state_next_s    = READY;
            end
         end
         CLEAR: begin
            if (clr_addr_r == LAST_ADDR) begin
               state_next_s    = READY;
               clr_addr_next_s = {ADDR_WIDTH{1'b0}};
            end else begin
               clr_addr_next_s = clr_addr_r + ADDR_ONE;
            end
         end
         default: begin
            state_next_s    = RESET_STATE;
            clr_addr_next_s = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   // Port A belongs to the clear engine while busy, otherwise to s1.
   always_comb begin
      if (busy_r) begin
         a_wen_s   = reset_n;
         a_addr_s  = clr_addr_r;
         a_be_s    = {BE_WIDTH{1'b1}};
         a_wdata_s = CLEAR_VALUE;
      end else begin
         a_wen_s   = reset_n & s1_wen_s;
         a_addr_s  = s1_address;
         a_be_s    = s1_byteenable;
         a_wdata_s = s1_writedata;
      end
   end

   // Control state, clear counter, collision counter and first read stage.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= RESET_STATE;
         clr_addr_r <= {ADDR_WIDTH{1'b0}};
         busy_r     <= (RESET_STATE == CLEAR);
         coll_r     <= {COUNT_WIDTH{1'b0}};
         s1_vld1_r  <= 1'b0;
         s2_vld1_r  <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         clr_addr_r <= clr_addr_next_s;
         busy_r     <= (state_next_s == CLEAR);
         s1_vld1_r  <= s1_ren_s;
         s2_vld1_r  <= s2_ren_s;
         if (overlap_s && (coll_r != 16'hFFFF)) begin
            coll_r <= coll_r + 16'd1;
         end
      end
   end

   controller_dpram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk     (clk),
      .reset_n (reset_n),
      .a_wen   (a_wen_s),
      .a_ren   (reset_n & s1_ren_s),
      .a_addr  (a_addr_s),
      .a_be    (a_be_s),
      .a_wdata (a_wdata_s),
      .a_q     (a_q_s),
      .b_wen   (reset_n & s2_wen_s),
      .b_ren   (reset_n & s2_ren_s),
      .b_addr  (s2_address),
      .b_be    (s2_be_eff_s),
      .b_wdata (s2_writedata),
      .b_q     (b_q_s)
   );

   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_rdata_r, s2_rdata_r;
      logic                  s1_vld2_r, s2_vld2_r;

      // Output register stage, loaded only when a response passes through.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            s1_rdata_r <= {DATA_WIDTH{1'b0}};
            s2_rdata_r <= {DATA_WIDTH{1'b0}};
            s1_vld2_r  <= 1'b0;
            s2_vld2_r  <= 1'b0;
         end else begin
            s1_vld2_r <= s1_vld1_r;
            s2_vld2_r <= s2_vld1_r;
            if (s1_vld1_r) begin
               s1_rdata_r <= a_q_s;
            end
            if (s2_vld1_r) begin
               s2_rdata_r <= b_q_s;
            end
         end
      end

      assign s1_readdata      = s1_rdata_r;
      assign s2_readdata      = s2_rdata_r;
      assign s1_readdatavalid = s1_vld2_r;
      assign s2_readdatavalid = s2_vld2_r;
   end else begin : g_lat1
      assign s1_readdata      = a_q_s;
      assign s2_readdata      = b_q_s;
      assign s1_readdatavalid = s1_vld1_r;
      assign s2_readdatavalid = s2_vld1_r;
   end

   assign busy            = busy_r;
   assign s1_waitrequest  = busy_r;
   assign s2_waitrequest  = busy_r;
   assign collision_count = coll_r;

endmodule

// File: tb/tb_controller_dpram_ctl.sv
// Scoreboard bench: two DUTs (read latency 1 and 2) share stimulus and are
// checked against a word-level memory model with expected-response queues.
module tb_controller_dpram_ctl;

   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   logic        clk;
   logic        reset_n, clear_req;
   logic        s1_cs, s1_rd, s1_wr, s2_cs, s2_rd, s2_wr;
   logic [3:0]  s1_addr, s2_addr, s1_be, s2_be;
   logic [31:0] s1_wd, s2_wd;

   logic [31:0] rdat [4];
   logic        rvld [4];
   logic        busy_v [2];
   logic        w1_v [2];
   logic        w2_v [2];
   logic [15:0] coll_v [2];

   exp_t        expq [4][$];
   logic [31:0] mem [DEPTH];
   logic [31:0] last [4];
   bit          m_busy = 1'b1;
   int          m_left = DEPTH;
   logic [15:0] m_coll = 16'h0000;
   bit          exp_busy;
   logic [15:0] exp_coll;
   int          cyc = 0;
   bit          started = 1'b0;
   bit          done = 1'b0;
   int          n_cmp = 0;
   int          n_fail = 0;

   controller_dpram_ctl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
                          .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0000_0000)) u_lat1 (
      .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy_v[0]),
      .collision_count(coll_v[0]),
      .s1_address(s1_addr), .s1_chipselect(s1_cs), .s1_read(s1_rd), .s1_write(s1_wr),
      .s1_byteenable(s1_be), .s1_writedata(s1_wd), .s1_readdata(rdat[0]),
      .s1_readdatavalid(rvld[0]), .s1_waitrequest(w1_v[0]),
      .s2_address(s2_addr), .s2_chipselect(s2_cs), .s2_read(s2_rd), .s2_write(s2_wr),
      .s2_byteenable(s2_be), .s2_writedata(s2_wd), .s2_readdata(rdat[1]),
      .s2_readdatavalid(rvld[1]), .s2_waitrequest(w2_v[0]));

   controller_dpram_ctl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2),
                          .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0000_0000)) u_lat2 (
      .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy_v[1]),
      .collision_count(coll_v[1]),
      .s1_address(s1_addr), .s1_chipselect(s1_cs), .s1_read(s1_rd), .s1_write(s1_wr),
      .s1_byteenable(s1_be), .s1_writedata(s1_wd), .s1_readdata(rdat[2]),
      .s1_readdatavalid(rvld[2]), .s1_waitrequest(w1_v[1]),
      .s2_address(s2_addr), .s2_chipselect(s2_cs), .s2_read(s2_rd), .s2_write(s2_wr),
      .s2_byteenable(s2_be), .s2_writedata(s2_wd), .s2_readdata(rdat[3]),
      .s2_readdatavalid(rvld[3]), .s2_waitrequest(w2_v[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: compares status every cycle and pops responses as they appear.
   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         for (int u = 0; u < 2; u++) begin
            chk("busy_waitrequest", {61'd0, busy_v[u], w1_v[u], w2_v[u]}, {61'd0, {3{exp_busy}}});
            chk("collision_count", {48'd0, coll_v[u]}, {48'd0, exp_coll});
         end
         for (int p = 0; p < 4; p++) begin
            if (!reset_n) begin
               chk("reset_read_outputs", {31'd0, rvld[p], rdat[p]}, 64'd0);
               last[p] = 32'h0;
            end else if (rvld[p]) begin
               if (expq[p].size() == 0) begin
                  chk("unexpected_readdatavalid", {63'd0, rvld[p]}, 64'd0);
               end else begin
                  e = expq[p].pop_front();
                  chk("readdata", {32'd0, rdat[p]}, {32'd0, e.d});
                  chk("read_latency", 64'(cyc), 64'(e.due));
               end
               last[p] = rdat[p];
            end else begin
               chk("readdata_hold", {32'd0, rdat[p]}, {32'd0, last[p]});
               if (expq[p].size() != 0 && expq[p][0].due <= cyc) begin
                  chk("missing_readdatavalid", {63'd0, rvld[p]}, 64'd1);
                  e = expq[p].pop_front();
               end
            end
         end
         if (done) begin
            for (int p = 0; p < 4; p++) chk("responses_outstanding", 64'(expq[p].size()), 64'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
         end
      end
   end

   // Reference model: applies one clock edge of the current inputs.
   task automatic model_edge();
      logic        a1w, a1r, a2w, a2r, same;
      logic [31:0] o1, o2;
      if (!reset_n) begin
         m_busy = 1'b1;
         m_left = DEPTH;
         m_coll = 16'h0000;
         for (int p = 0; p < 4; p++) expq[p].delete();
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            foreach (mem[i]) mem[i] = 32'h0000_0000;
         end
      end else begin
         a1w = s1_cs && s1_wr;
         a1r = s1_cs && s1_rd && !s1_wr;
         a2w = s2_cs && s2_wr;
         a2r = s2_cs && s2_rd && !s2_wr;
         o1 = mem[s1_addr];
         o2 = mem[s2_addr];
         if (a1r) begin
            expq[0].push_back(exp_t'{d: o1, due: cyc + 1});
            expq[2].push_back(exp_t'{d: o1, due: cyc + 2});
         end
         if (a2r) begin
            expq[1].push_back(exp_t'{d: o2, due: cyc + 1});
            expq[3].push_back(exp_t'{d: o2, due: cyc + 2});
         end
         same = a1w && a2w && (s1_addr == s2_addr);
         for (int i = 0; i < 4; i++) begin
            if (a1w && s1_be[i]) mem[s1_addr][8*i +: 8] = s1_wd[8*i +: 8];
            if (a2w && s2_be[i] && !(same && s1_be[i])) mem[s2_addr][8*i +: 8] = s2_wd[8*i +: 8];
         end
         if (same && ((s1_be & s2_be) != 4'b0000) && (m_coll != 16'hFFFF)) m_coll++;
         if (clear_req) begin
            m_busy = 1'b1;
            m_left = DEPTH;
         end
      end
      exp_busy = m_busy;
      exp_coll = m_coll;
   endtask

   task automatic step();
      model_edge();
      started = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      s1_cs = 1'b0; s1_rd = 1'b0; s1_wr = 1'b0;
      s2_cs = 1'b0; s2_rd = 1'b0; s2_wr = 1'b0;
      clear_req = 1'b0;
   endtask

   task automatic set1(input logic rd, input logic wr, input logic [3:0] a,
                       input logic [3:0] be, input logic [31:0] d);
      s1_cs = 1'b1; s1_rd = rd; s1_wr = wr; s1_addr = a; s1_be = be; s1_wd = d;
   endtask

   task automatic set2(input logic rd, input logic wr, input logic [3:0] a,
                       input logic [3:0] be, input logic [31:0] d);
      s2_cs = 1'b1; s2_rd = rd; s2_wr = wr; s2_addr = a; s2_be = be; s2_wd = d;
   endtask

   // Holds the presented request until the model says it was accepted.
   task automatic issue();
      bit acc;
      for (int k = 0; k < 64; k++) begin
         acc = !m_busy;
         step();
         if (acc) break;
      end
   endtask

   task automatic rand_port(output logic cs, output logic rd, output logic wr,
                            output logic [3:0] a, output logic [3:0] be, output logic [31:0] d);
      cs = ($urandom_range(3) != 0);
      rd = 1'($urandom_range(1));
      wr = 1'($urandom_range(1));
      a  = 4'($urandom_range(7));
      be = 4'($urandom_range(15));
      d  = $urandom;
   endtask

   initial begin
      foreach (mem[i]) mem[i] = 32'h0000_0000;
      s1_addr = 4'h0; s2_addr = 4'h0; s1_be = 4'h0; s2_be = 4'h0;
      s1_wd = 32'h0; s2_wd = 32'h0;
      idle();
      reset_n = 1'b0;
      step(); step();
      reset_n = 1'b1;
      repeat (18) step();
      for (int a = 0; a < DEPTH; a++) begin
         set1(1'b1, 1'b0, 4'(a), 4'hF, 32'h0);
         set2(1'b1, 1'b0, 4'(15 - a), 4'hF, 32'h0);
         step();
      end
      idle(); repeat (3) step();

      set1(1'b0, 1'b1, 4'd5, 4'hF, 32'hDEAD_BEEF); step();
      set1(1'b1, 1'b0, 4'd5, 4'hF, 32'h0); step();
      idle(); repeat (3) step();

      set1(1'b0, 1'b1, 4'd3, 4'b0011, 32'h1111_1111);
      set2(1'b0, 1'b1, 4'd3, 4'b0110, 32'h2222_2222); step();
      idle(); set1(1'b1, 1'b0, 4'd3, 4'hF, 32'h0); step();
      idle(); repeat (3) step();

      set1(1'b0, 1'b1, 4'd7, 4'hF, 32'hAAAA_5555); step();
      set1(1'b0, 1'b1, 4'd7, 4'hF, 32'h1234_5678);
      set2(1'b1, 1'b0, 4'd7, 4'hF, 32'h0); step();
      idle(); set2(1'b1, 1'b0, 4'd7, 4'hF, 32'h0); step();
      idle(); repeat (3) step();

      set2(1'b1, 1'b0, 4'd7, 4'hF, 32'h0); step();
      set2(1'b1, 1'b0, 4'd5, 4'hF, 32'h0); clear_req = 1'b1; step();
      clear_req = 1'b0; set2(1'b1, 1'b0, 4'd3, 4'hF, 32'h0); issue();
      idle(); step();
      for (int a = 0; a < DEPTH; a++) begin
         set2(1'b1, 1'b0, 4'(a), 4'hF, 32'h0); step();
      end
      idle(); repeat (3) step();

      for (int i = 0; i < 65540; i++) begin
         set1(1'b0, 1'b1, 4'd9, 4'b0001, $urandom);
         set2(1'b0, 1'b1, 4'd9, 4'b0011, $urandom);
         step();
      end
      idle(); set1(1'b1, 1'b0, 4'd9, 4'hF, 32'h0); step();
      idle(); repeat (3) step();

      clear_req = 1'b1; step();
      clear_req = 1'b0; repeat (6) step();
      reset_n = 1'b0; step();
      reset_n = 1'b1; repeat (18) step();

      for (int i = 0; i < 3000; i++) begin
         if (!m_busy) begin
            rand_port(s1_cs, s1_rd, s1_wr, s1_addr, s1_be, s1_wd);
            rand_port(s2_cs, s2_rd, s2_wr, s2_addr, s2_be, s2_wd);
            clear_req = ($urandom_range(49) == 0);
         end else begin
            clear_req = 1'b0;
         end
         reset_n = ($urandom_range(299) != 0);
         step();
      end
      reset_n = 1'b1;
      idle(); repeat (20) step();
      done = 1'b1;
      step();
      step();
   end

endmodule

// File: doc/controller_dpram_ctl.md
Name: controller_dpram_ctl

Overview:
Parametrised true dual-port on-chip RAM with two Avalon-MM slave ports, s1 and s2, on a single clock. It succeeds the fixed 1024x32 data RAM in the controller subsystem. It adds configurable width, depth and read latency, a hardware clear engine (after reset and on request), and deterministic same-address write arbitration with a saturating collision counter. It sits between the Nios data masters and the controller datapath as shared scratch/mailbox memory.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8.
ADDR_WIDTH, 10, word address width; DEPTH = 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2 (2 = registered output).
CLEAR_ON_RESET, 1, 1 = run the clear engine after reset; 0 = ready immediately.
CLEAR_VALUE, 0, word written to every location by the clear engine.

Ports:
clk  in  1  single clock.
reset_n  in  1  reset; synchronous, active-low.
clear_req  in  1  one-cycle pulse; starts a clear pass.
busy  out  1  high while clearing.
collision_count  out  16  saturating count of same-address s1/s2 write collisions.
s1_address / s2_address  in  ADDR_WIDTH  word address.
s1_chipselect / s2_chipselect  in  1  port select.
s1_read / s2_read  in  1  read request.
s1_write / s2_write  in  1  write request.
s1_byteenable / s2_byteenable  in  DATA_WIDTH/8  byte lanes.
s1_writedata / s2_writedata  in  DATA_WIDTH  write data.
s1_readdata / s2_readdata  out  DATA_WIDTH  read data.
s1_readdatavalid / s2_readdatavalid  out  1  read data qualifier.
s1_waitrequest / s2_waitrequest  out  1  transfer stall.

Behaviour:
- Reset: the clk edge with reset_n=0 gives:
  - state = CLEAR if CLEAR_ON_RESET, else READY;
  - clear counter = 0; collision_count = 0;
  - readdatavalid = 0 and readdata = 0 on both ports;
  - read pipelines flushed; array contents untouched.
  Reset during CLEAR restarts the pass from address 0.
- States: READY and CLEAR.
  - waitrequest = busy = (state == CLEAR). Both are registered outputs, not combinational.
  - Transfer accepted = chipselect & (read | write) & ~waitrequest.
- CLEAR:
  - Each cycle writes CLEAR_VALUE to the counter address with all bytes enabled, then increments the counter.
  - When the counter reaches DEPTH-1 that address is written and the next state is READY.
  - A pass lasts exactly DEPTH cycles. Port requests are stalled, not dropped.
- READY plus clear_req: transfers presented that cycle are accepted (waitrequest is already 0). The state is CLEAR from the next cycle. clear_req during CLEAR is ignored.
- Reads:
  - readdatavalid pulses exactly READ_LATENCY cycles after acceptance; one response per accepted read, in order.
  - A full-rate read stream is supported.
  - Reads accepted before a clear starts still complete during CLEAR with pre-clear data.
  - readdata holds its last value when readdatavalid = 0.
- read and write asserted together on one port: the write is performed and no readdatavalid is generated.
- Writes are committed at the accepting edge; byteenable=0 lanes are unchanged.
- Same-address write/write in one cycle:
  - s1 wins per byte lane, i.e. s2 effective byteenable = s2_byteenable & ~s1_byteenable.
  - Disjoint lanes merge.
  - collision_count increments by 1 if the lane sets overlap, saturating at 0xFFFF.
- Mixed-port read during write (same address, same cycle): the reader gets OLD data.
- Same-port read-after-write on the next cycle returns the new data.
- Address width is exact; no wrap or out-of-range handling is needed.

Decomposition:
- Package controller_dpram_pkg holds:
  - state enum {READY, CLEAR};
  - the READ_LATENCY legality check function;
  - localparam widths: BE_WIDTH = DATA_WIDTH/8 and the 16-bit counter width.
- Sub-module controller_dpram_array:
  - inferred true dual-port byte-enabled RAM with registered reads;
  - old-data mixed-port behaviour;
  - parameters DATA_WIDTH and ADDR_WIDTH.
- The top level owns the clear FSM, the port/clear-engine mux, collision masking, the latency pipelines and the counter.

Test Plan:
- Reset_n low 2 cycles with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> waitrequest/busy high for exactly 16 cycles, then low; every address reads 0x00000000.
- Write s1 addr 5 = 0xDEADBEEF, read it next cycle with READ_LATENCY=1 and then =2 -> readdatavalid 1 or 2 cycles after acceptance respectively, data 0xDEADBEEF.
- Same cycle: s1 writes addr 3 = 0x11111111 be=0011, s2 writes addr 3 = 0x22222222 be=0110 -> word = 0x00221111 (lane 1 from s1, lane 2 from s2); collision_count = 1.
- Addr 7 holds 0xAAAA5555; s1 writes 0x12345678 while s2 reads addr 7 in the same cycle -> s2 gets 0xAAAA5555; a following read gets 0x12345678.
- Back-to-back s2 reads issued and clear_req pulsed in the same cycle -> all accepted reads return pre-clear data; waitrequest rises next cycle; memory is zero afterwards.
- Force collision_count to 0xFFFE, then 3 colliding writes -> count = 0xFFFF and holds; reset_n low mid-clear -> counter restarts and busy lasts a full DEPTH cycles.
